// File: rtl/i2c_pwm_pkg.sv
// Shared types and constants for the I2C-to-PWM register front end.
//   - CMPA_W      : width of the committed compare word
//   - LoW/MidW/HiW: widths of the three staging fields that make up cmpa
//   - Reg*        : register-map indices addressed by the 2-bit pointer
//   - i2c_state_e : protocol FSM states (read states only with I2C_PWM_READ_EN)
//   - pack_cmpa   : assembles the compare word from the staging fields
package i2c_pwm_pkg;

  localparam int unsigned CMPA_W = 19;

  localparam int unsigned LoW  = 8;
  localparam int unsigned MidW = 8;
  localparam int unsigned HiW  = 3;

  localparam logic [1:0] RegLo     = 2'd0;
  localparam logic [1:0] RegMid    = 2'd1;
  localparam logic [1:0] RegHi     = 2'd2;
  localparam logic [1:0] RegCommit = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StData,
    StDataAck,
    StIgnore
`ifdef I2C_PWM_READ_EN
    ,
    StRead,
    StReadAck
`endif
  } i2c_state_e;

  function automatic logic [CMPA_W-1:0] pack_cmpa(input logic [HiW-1:0]  hi,
                                                  input logic [MidW-1:0] mid,
                                                  input logic [LoW-1:0]  lo);
    return {hi, mid, lo};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser and glitch filter for one I2C line.
// A raw asynchronous pin passes through a 2-flop synchroniser; the filtered level only
// changes after FiltLen consecutive synchronised samples disagree with it. Rise/fall
// strobes are single-cycle pulses aligned with the cycle the new level appears.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (level resets to 1, the idle bus level)
//   raw_i   raw pin level
//   level_o filtered level
//   rise_o  one-cycle pulse when level_o goes 0 -> 1
//   fall_o  one-cycle pulse when level_o goes 1 -> 0
module i2c_line_filter #(
  parameter int unsigned FiltLen = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [2:0] cnt_q;
  logic       filt_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      cnt_q  <= 3'd0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == filt_q) begin
        // Any agreeing sample restarts the run, so short glitches never accumulate.
        cnt_q <= 3'd0;
      end else if (cnt_q == 3'(FiltLen - 1)) begin
        cnt_q  <= 3'd0;
        filt_q <= sync_q[1];
        rise_q <= sync_q[1];
        fall_q <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign level_o = filt_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_pwm_regs.sv
// I2C target front end for the PWM controller.
// Receives byte writes on SCL/SDA into a 4-byte map; a write to the commit register
// copies the staged fields into cmpa atomically and pulses cmpa_upd.
// Map: 0 = cmpa[7:0], 1 = cmpa[15:8], 2 = cmpa[18:16] (bits 7:3 ignored), 3 = commit.
// Optional feature macro: I2C_PWM_READ_EN enables register reads (R/W=1).
// Ports:
//   clk_USB  system clock (12 MHz)
//   rstn     asynchronous active-low reset
//   scl_in   raw SCL pin
//   sda_in   raw SDA pin
//   sda_oe   1 = pull SDA low
//   cmpa     committed compare word {period, dither, phase}
//   cmpa_upd one-cycle pulse when cmpa changes
//   busy     high from an own-address START to STOP
module i2c_pwm_regs
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0]        DEV_ADDR   = 7'h52,
  parameter int unsigned       FILT_LEN   = 3,
  parameter logic [CMPA_W-1:0] CMPA_RESET = 19'h0
) (
  input  logic              clk_USB,
  input  logic              rstn,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [CMPA_W-1:0] cmpa,
  output logic              cmpa_upd,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(
    .FiltLen (FILT_LEN)
  ) u_scl_filter (
    .clk_i   (clk_USB),
    .rst_ni  (rstn),
    .raw_i   (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(
    .FiltLen (FILT_LEN)
  ) u_sda_filter (
    .clk_i   (clk_USB),
    .rst_ni  (rstn),
    .raw_i   (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        shift_q;
  logic [1:0]        ptr_q;
  logic              ack_on_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic [LoW-1:0]    reg_lo_q;
  logic [MidW-1:0]   reg_mid_q;
  logic [HiW-1:0]    reg_hi_q;
  logic              commit_q;
  logic [CMPA_W-1:0] cmpa_q;
  logic              cmpa_upd_q;

  // Byte as it stands including the bit being sampled on this SCL rise.
  logic [7:0] rx_byte;
  assign rx_byte = {shift_q, sda_lvl};

`ifdef I2C_PWM_READ_EN
  logic       rd_mode_q;
  logic       tx_first_q;
  logic [7:0] tx_q;
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    unique case (ptr_q)
      RegLo:     rd_data = reg_lo_q;
      RegMid:    rd_data = reg_mid_q;
      RegHi:     rd_data = {{(8 - HiW){1'b0}}, reg_hi_q};
      RegCommit: rd_data = {{(8 - HiW){1'b0}}, cmpa_q[CMPA_W-1:LoW+MidW]};
    endcase
  end
`endif

  always_ff @(posedge clk_USB or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      ptr_q      <= 2'd0;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      reg_lo_q   <= CMPA_RESET[LoW-1:0];
      reg_mid_q  <= CMPA_RESET[LoW+MidW-1:LoW];
      reg_hi_q   <= CMPA_RESET[CMPA_W-1:LoW+MidW];
      commit_q   <= 1'b0;
      cmpa_q     <= CMPA_RESET;
      cmpa_upd_q <= 1'b0;
`ifdef I2C_PWM_READ_EN
      rd_mode_q  <= 1'b0;
      tx_first_q <= 1'b0;
      tx_q       <= 8'h00;
`endif
    end else begin
      // Commit lands one clock after the reg3 write, well inside the ACK bit.
      commit_q   <= 1'b0;
      cmpa_upd_q <= commit_q;
      if (commit_q) begin
        cmpa_q <= pack_cmpa(reg_hi_q, reg_mid_q, reg_lo_q);
      end

      if (start_det) begin
        // Repeated START wins over any partial byte or pending ACK.
        state_q   <= StAddr;
        bit_cnt_q <= 3'd0;
        ack_on_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= 3'd0;
        ack_on_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
                  state_q <= StAddrAck;
                  busy_q  <= 1'b1;
`ifdef I2C_PWM_READ_EN
                  rd_mode_q <= 1'b0;
                end else if (rx_byte[7:1] == DEV_ADDR) begin
                  state_q   <= StAddrAck;
                  busy_q    <= 1'b1;
                  rd_mode_q <= 1'b1;
`endif
                end else begin
                  state_q <= StIgnore;
                  busy_q  <= 1'b0;
                end
              end
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
`ifdef I2C_PWM_READ_EN
                if (rd_mode_q) begin
                  // ACK release and first data bit share this SCL fall.
                  tx_q       <= rd_data;
                  tx_first_q <= 1'b0;
                  sda_oe_q   <= ~rd_data[7];
                  state_q    <= StRead;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= StPtr;
                end
`else
                sda_oe_q <= 1'b0;
                state_q  <= StPtr;
`endif
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= rx_byte[1:0];
                state_q <= StPtrAck;
              end
            end
          end

          StData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                unique case (ptr_q)
                  RegLo:     reg_lo_q  <= rx_byte;
                  RegMid:    reg_mid_q <= rx_byte;
                  RegHi:     reg_hi_q  <= rx_byte[HiW-1:0];
                  RegCommit: commit_q  <= 1'b1;
                endcase
                ptr_q   <= ptr_q + 2'd1;
                state_q <= StDataAck;
              end
            end
          end

          StPtrAck, StDataAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_on_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= StData;
              end
            end
          end

`ifdef I2C_PWM_READ_EN
          StRead: begin
            if (scl_fall) begin
              if (tx_first_q) begin
                tx_first_q <= 1'b0;
                sda_oe_q   <= ~tx_q[7];
              end else begin
                tx_q     <= {tx_q[6:0], 1'b0};
                sda_oe_q <= ~tx_q[6];
              end
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= ptr_q + 2'd1;
                state_q <= StReadAck;
              end
            end
          end

          StReadAck: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_lvl) begin
                tx_q       <= rd_data;
                tx_first_q <= 1'b1;
                bit_cnt_q  <= 3'd0;
                state_q    <= StRead;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
`endif

          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign cmpa     = cmpa_q;
  assign cmpa_upd = cmpa_upd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// Directed bench for i2c_pwm_regs: bit-banged I2C master with open-drain SDA model.
module tb_i2c_pwm_regs;

  localparam int Q = 8;  // system clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rstn;
  logic        scl_m;
  logic        sda_m;
  logic        glitch;
  logic        sda_pin;
  logic        sda_oe;
  logic [18:0] cmpa;
  logic        cmpa_upd;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;
  int oe_cnt = 0;

  logic [7:0] txq[$];

  always #5 clk = ~clk;

  assign sda_pin = sda_oe ? 1'b0 : (sda_m & ~glitch);

  i2c_pwm_regs dut (
    .clk_USB  (clk),
    .rstn     (rstn),
    .scl_in   (scl_m),
    .sda_in   (sda_pin),
    .sda_oe   (sda_oe),
    .cmpa     (cmpa),
    .cmpa_upd (cmpa_upd),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (rstn && cmpa_upd) upd_cnt <= upd_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic qw(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw(1);
    scl_m = 1'b1; qw(1);
    sda_m = 1'b0; qw(1);
    scl_m = 1'b0; qw(1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw(1);
    scl_m = 1'b1; qw(1);
    sda_m = 1'b1; qw(2);
  endtask

  // Sends the top n bits of b; gbit selects a bit whose high phase gets a 1-clock SDA dip.
  task automatic send_bits(input logic [7:0] b, input int n, input int gbit);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; qw(1);
      scl_m = 1'b1; qw(1);
      if (i == gbit) begin
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (Q - 1) @(negedge clk);
      end else begin
        qw(1);
      end
      scl_m = 1'b0; qw(1);
    end
  endtask

  task automatic ack_bit(output logic acked);
    sda_m = 1'b1; qw(1);
    scl_m = 1'b1; qw(1);
    acked = ~sda_pin;
    qw(1);
    scl_m = 1'b0; qw(1);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8, -1);
    ack_bit(acked);
  endtask

  task automatic write_txn(output int acks);
    logic a;
    acks = 0;
    i2c_start();
    foreach (txq[i]) begin
      write_byte(txq[i], a);
      if (a) acks++;
    end
    i2c_stop();
  endtask

`ifdef I2C_PWM_READ_EN
  task automatic read_byte(output logic [7:0] d, input logic nack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qw(1);
      scl_m = 1'b1; qw(1);
      d[i] = sda_pin;
      qw(1);
      scl_m = 1'b0; qw(1);
    end
    sda_m = nack; qw(1);
    scl_m = 1'b1; qw(2);
    scl_m = 1'b0; qw(1);
    sda_m = 1'b1;
  endtask
`endif

  initial begin
    int   acks;
    int   upd0;
    int   oe0;
    logic a;
`ifdef I2C_PWM_READ_EN
    logic [7:0] rd;
`endif

    rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1; glitch = 1'b0;
    repeat (5) @(negedge clk);
    check("reset sda_oe", 32'(sda_oe), 32'd0);
    check("reset cmpa", 32'(cmpa), 32'h0);
    check("reset cmpa_upd", 32'(cmpa_upd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Separate staging writes, then commit.
    upd0 = upd_cnt;
    i2c_start();
    write_byte(8'hA4, a);
    check("t1 addr ack", 32'(a), 32'd1);
    check("t1 busy high", 32'(busy), 32'd1);
    write_byte(8'h00, a);
    write_byte(8'h44, a);
    check("t1 data ack", 32'(a), 32'd1);
    i2c_stop();
    check("t1 busy low after stop", 32'(busy), 32'd0);
    txq = '{8'hA4, 8'h01, 8'h13};
    write_txn(acks);
    txq = '{8'hA4, 8'h02, 8'h00};
    write_txn(acks);
    check("t1 cmpa before commit", 32'(cmpa), 32'h0);
    check("t1 no upd before commit", 32'(upd_cnt - upd0), 32'd0);
    txq = '{8'hA4, 8'h03, 8'h00};
    write_txn(acks);
    check("t1 commit acks", 32'(acks), 32'd3);
    check("t1 cmpa", 32'(cmpa), 32'h01344);
    check("t1 one upd", 32'(upd_cnt - upd0), 32'd1);

    // Burst with pointer auto-increment through the commit register.
    upd0 = upd_cnt;
    txq = '{8'hA4, 8'h00, 8'h44, 8'h13, 8'h05, 8'h00};
    write_txn(acks);
    check("t2 acks", 32'(acks), 32'd6);
    check("t2 cmpa", 32'(cmpa), 32'h51344);
    check("t2 one upd", 32'(upd_cnt - upd0), 32'd1);

    // Foreign address: never ACKed, nothing written.
    upd0 = upd_cnt;
    oe0  = oe_cnt;
    txq = '{8'hA6, 8'h00, 8'h11, 8'h03, 8'h00};
    write_txn(acks);
    check("t3 acks", 32'(acks), 32'd0);
    check("t3 sda_oe never", 32'(oe_cnt - oe0), 32'd0);
    check("t3 cmpa", 32'(cmpa), 32'h51344);
    check("t3 no upd", 32'(upd_cnt - upd0), 32'd0);

    // STOP after a partial data byte must not write reg0.
    i2c_start();
    write_byte(8'hA4, a);
    write_byte(8'h00, a);
    send_bits(8'h77, 4, -1);
    i2c_stop();
    upd0 = upd_cnt;
    txq = '{8'hA4, 8'h03, 8'h00};
    write_txn(acks);
    check("t4 cmpa after partial", 32'(cmpa), 32'h51344);
    check("t4 upd", 32'(upd_cnt - upd0), 32'd1);
    txq = '{8'hA4, 8'h00, 8'h21, 8'h13, 8'h05, 8'h00};
    write_txn(acks);
    check("t4 next acks", 32'(acks), 32'd6);
    check("t4 next cmpa", 32'(cmpa), 32'h51321);

    // 1-clock SDA dip while SCL high must not be seen as START/STOP.
    upd0 = upd_cnt;
    i2c_start();
    write_byte(8'hA4, a);
    write_byte(8'h03, a);
    send_bits(8'h80, 8, 7);
    ack_bit(a);
    check("t5 glitch byte ack", 32'(a), 32'd1);
    check("t5 busy kept", 32'(busy), 32'd1);
    i2c_stop();
    check("t5 upd", 32'(upd_cnt - upd0), 32'd1);
    check("t5 cmpa", 32'(cmpa), 32'h51321);

    // Reset in the middle of a data byte.
    i2c_start();
    write_byte(8'hA4, a);
    write_byte(8'h00, a);
    send_bits(8'h99, 4, -1);
    rstn = 1'b0;
    #1;
    check("t6 reset sda_oe", 32'(sda_oe), 32'd0);
    check("t6 reset cmpa", 32'(cmpa), 32'h0);
    check("t6 reset busy", 32'(busy), 32'd0);
    check("t6 reset upd", 32'(cmpa_upd), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    send_bits(8'h90, 4, -1);
    ack_bit(a);
    check("t6 no ack after reset", 32'(a), 32'd0);
    i2c_stop();
    check("t6 cmpa held", 32'(cmpa), 32'h0);
    txq = '{8'hA4, 8'h00, 8'h44, 8'h13, 8'h05, 8'h00};
    write_txn(acks);
    check("t6 recover acks", 32'(acks), 32'd6);
    check("t6 recover cmpa", 32'(cmpa), 32'h51344);

`ifdef I2C_PWM_READ_EN
    i2c_start();
    write_byte(8'hA4, a);
    write_byte(8'h00, a);
    i2c_start();
    write_byte(8'hA5, a);
    check("rd addr ack", 32'(a), 32'd1);
    read_byte(rd, 1'b1);
    i2c_stop();
    check("rd reg0", 32'(rd), 32'h44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
